// File: rtl/adder_rx_pkg.sv
// Shared parameters and types for the NoC adder receive path.
package adder_rx_pkg;

  // AXI-stream field widths of the NoC slave interface
  localparam int AXIS_MAX_DATAW = 128;
  localparam int AXIS_USERW     = 8;
  localparam int AXIS_DESTW     = 8;
  localparam int AXIS_IDW       = 4;
  localparam int AXIS_STRBW     = AXIS_MAX_DATAW / 8;
  localparam int AXIS_KEEPW     = AXIS_MAX_DATAW / 8;

  // Adder endpoint sizing
  localparam int DATAW      = 128;
  localparam int FIFO_DEPTH = 16;
  localparam int ACCW       = 64;
  localparam int CNTW       = 16;

  // NoC addresses of the transmitter and of this endpoint
  localparam logic [AXIS_USERW-1:0] SRC_ADDR  = 8'h21;
  localparam logic [AXIS_DESTW-1:0] DEST_ADDR = 8'h42;

  // Receiver state: summing beats, or holding a finished packet result
  typedef enum logic {
    ST_ACCUM  = 1'b0,
    ST_RESULT = 1'b1
  } rx_state_e;

endpackage

// File: rtl/adder_rx_fifo.sv
// Synchronous FIFO with async active-high reset; output shows the head entry.
module rx_fifo #(
  parameter int WIDTH = 129,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             push_ok, pop_ok;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  // Advance the wrapping pointers; the extra MSB tells full from empty
  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
  end

  // Pointer registers, cleared asynchronously so the FIFO empties on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; entries are only read once the pointers cover them
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/adder_rx.sv
// AXI-stream endpoint that sums the low 64-bit lane of each packet's beats.
module adder_rx
  import adder_rx_pkg::*;
#(
  parameter int                    P_DATAW      = DATAW,
  parameter int                    P_ACCW       = ACCW,
  parameter int                    P_FIFO_DEPTH = FIFO_DEPTH,
  parameter int                    P_CNTW       = CNTW,
  parameter logic [AXIS_USERW-1:0] EXP_SRC      = SRC_ADDR
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      axis_adder_interface_tvalid,
  output logic                      axis_adder_interface_tready,
  input  logic [AXIS_MAX_DATAW-1:0] axis_adder_interface_tdata,
  input  logic                      axis_adder_interface_tlast,
  input  logic [AXIS_USERW-1:0]     axis_adder_interface_tuser,
  input  logic [AXIS_DESTW-1:0]     axis_adder_interface_tdest,
  input  logic [AXIS_IDW-1:0]       axis_adder_interface_tid,
  input  logic [AXIS_STRBW-1:0]     axis_adder_interface_tstrb,
  input  logic [AXIS_KEEPW-1:0]     axis_adder_interface_tkeep,
  output logic                      result_valid,
  input  logic                      result_ready,
  output logic [P_ACCW-1:0]         result_sum,
  output logic [P_CNTW-1:0]         result_count,
  output logic                      src_err
);

  rx_state_e          state_q, state_d;
  logic [P_ACCW-1:0]  acc_q, acc_d;
  logic [P_CNTW-1:0]  cnt_q, cnt_d;
  logic               result_valid_q, result_valid_d;
  logic [P_ACCW-1:0]  result_sum_q, result_sum_d;
  logic [P_CNTW-1:0]  result_count_q, result_count_d;
  logic               src_err_q, src_err_d;

  logic               push, pop;
  logic               fifo_full, fifo_empty;
  logic [P_DATAW:0]   fifo_dout;
  logic [P_ACCW-1:0]  beat_val, sum_now;
  logic [P_CNTW-1:0]  cnt_inc;
  logic               unused_inputs;

  assign axis_adder_interface_tready = !fifo_full && !rst;
  assign push = axis_adder_interface_tvalid && axis_adder_interface_tready;

  assign unused_inputs = ^{axis_adder_interface_tdest, axis_adder_interface_tid,
                           axis_adder_interface_tstrb, axis_adder_interface_tkeep,
                           axis_adder_interface_tdata, fifo_dout};

  rx_fifo #(
    .WIDTH (P_DATAW + 1),
    .DEPTH (P_FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({axis_adder_interface_tlast, axis_adder_interface_tdata[P_DATAW-1:0]}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign beat_val = P_ACCW'(fifo_dout[63:0]);
  assign sum_now  = acc_q + beat_val;
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + P_CNTW'(1);

  // Next-state logic: drain one beat per cycle while accumulating, park on a result
  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    result_valid_d = result_valid_q;
    result_sum_d   = result_sum_q;
    result_count_d = result_count_q;
    pop            = 1'b0;
    src_err_d      = src_err_q || (push && (axis_adder_interface_tuser != EXP_SRC));
    case (state_q)
      ST_ACCUM: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (fifo_dout[P_DATAW]) begin
            result_sum_d   = sum_now;
            result_count_d = cnt_inc;
            result_valid_d = 1'b1;
            acc_d          = '0;
            cnt_d          = '0;
            state_d        = ST_RESULT;
          end else begin
            acc_d = sum_now;
            cnt_d = cnt_inc;
          end
        end
      end
      ST_RESULT: begin
        if (result_ready) begin
          result_valid_d = 1'b0;
          state_d        = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  // State and registered outputs; reset discards partial sums and pending results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_ACCUM;
      acc_q          <= '0;
      cnt_q          <= '0;
      result_valid_q <= 1'b0;
      result_sum_q   <= '0;
      result_count_q <= '0;
      src_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      result_valid_q <= result_valid_d;
      result_sum_q   <= result_sum_d;
      result_count_q <= result_count_d;
      src_err_q      <= src_err_d;
    end
  end

  assign result_valid = result_valid_q;
  assign result_sum   = result_sum_q;
  assign result_count = result_count_q;
  assign src_err      = src_err_q;

endmodule

// File: doc/adder_rx.md
Name: adder_rx

Overview:
- AXI-stream receiving endpoint for the NoC adder path. It accepts beats addressed to the adder, buffers them, and sums the low 64-bit lane of every beat in a packet.
- A packet is the run of beats up to and including the beat with tlast set. At tlast it presents the packet sum and beat count on a valid/ready result port.
- It sits behind the NoC AXIS slave interface, opposite the client-side transmitter.

Parameters:
- DATAW, 128, width of the tdata payload stored per beat (>= 64).
- ACCW, 64, accumulator/result width; sum is modulo 2^ACCW.
- FIFO_DEPTH, 16, input buffer depth in beats; power of two, >= 2.
- CNTW, 16, beat-count width; count saturates at 2^CNTW-1.
- EXP_SRC, `SRC_ADDR, tuser value expected from the transmitter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- axis_adder_interface_tvalid  in  1  beat valid
- axis_adder_interface_tready  out  1  beat accepted when tvalid & tready
- axis_adder_interface_tdata  in  `AXIS_MAX_DATAW  payload; only [DATAW-1:0] stored, [63:0] summed
- axis_adder_interface_tlast  in  1  last beat of packet
- axis_adder_interface_tuser  in  `AXIS_USERW  source address
- axis_adder_interface_tdest  in  `AXIS_DESTW  ignored
- axis_adder_interface_tid / tstrb / tkeep  in  `AXIS_IDW / `AXIS_STRBW / `AXIS_KEEPW  ignored
- result_valid  out  1  result held
- result_ready  in  1  consumer accepts result
- result_sum  out  ACCW  packet sum
- result_count  out  CNTW  beats in packet
- src_err  out  1  sticky: a beat arrived with tuser != EXP_SRC

Behaviour:
- One clock, clk. Reset rst is asynchronous active-high and clears everything immediately.
- Reset values: tready=0 while rst is high, then ~full; result_valid=0, result_sum=0, result_count=0, src_err=0. FIFO is empty and the state is ACCUM.
- Input side:
  - tready = ~fifo_full; independent of result_ready.
  - On accept, push {tlast, tdata[DATAW-1:0]}.
  - tuser mismatch sets src_err at the next edge; the beat is still summed.
- FIFO:
  - Registered write; written data is visible at the output the cycle after the write edge.
  - Simultaneous push and pop when full is disallowed, because tready=0 when full.
  - Simultaneous push and pop when non-empty keeps occupancy constant.
- State machine:
  - ACCUM: pop whenever non-empty. Per pop: acc <= acc + data[63:0] (mod 2^ACCW); cnt <= sat(cnt+1).
    - If the popped beat has last=1: result_sum <= acc + data[63:0], result_count <= sat(cnt+1), result_valid <= 1, acc <= 0, cnt <= 0, go to RESULT.
  - RESULT: no pops; the FIFO continues to fill until full.
    - result_sum and result_count are held stable while result_valid=1.
    - On result_valid & result_ready: result_valid <= 0, go to ACCUM; popping resumes the next cycle.
- Latency:
  - Last beat accepted at edge E → popped at edge E+1 → result_valid=1 in the cycle after E+1.
  - Throughput in ACCUM is 1 beat/cycle.
- Boundaries:
  - Single-beat packet: sum = that beat, count = 1.
  - Sum wraps at 2^ACCW without a flag.
  - Count saturates at 2^CNTW-1.
  - Back-to-back packets: the next packet's beats wait in the FIFO during RESULT, costing at least 1 bubble cycle per packet.
  - rst asserted mid-packet or in RESULT: partial sum, buffered beats and a pending result are discarded.
  - After rst deasserts, tready rises in the same cycle (FIFO empty).

Decomposition:
- Shared include static_params.vh already carries DATAW, FIFO_DEPTH, AXIS_*W, SRC_ADDR and DEST_ADDR. Add ACCW and CNTW there.
- One sub-module: rx_fifo, a width/depth-parameterised synchronous FIFO with asynchronous active-high reset and full/empty flags. It stores DATAW+1 bits.
- State encoding is a two-state localparam inside adder_rx.

Test Plan:
- Packet beats 5, 7, 11 (tlast on 11), tuser=EXP_SRC, result_ready=1 → result_valid 2 cycles after the 11 is accepted; sum=23, count=3; src_err=0.
- Single beat 0xFFFFFFFFFFFFFFFF, then packet {1, 1 tlast} (ACCW=64) → first result sum=0xFFFFFFFFFFFFFFFF, count=1; second sum=2, count=2. Also 0xFFFFFFFFFFFFFFFF + 2 → sum=1 (wrap).
- result_ready=0 held for 40 cycles while 20 beats stream (packet of 4, then 16) → first result stable throughout; tready drops after 16 more beats are buffered. On release: second sum correct, no beat lost or duplicated.
- Beat with tuser=EXP_SRC+1, value 9, tlast → sum=9, count=1; src_err=1 and stays 1 until rst.
- Assert rst asynchronously mid-packet after beats 3, 4 → outputs clear without a clock edge. Next packet {10 tlast} → sum=10, count=1.
- Random tvalid/result_ready throttling, 1000 packets of length 1–20 → every result matches a scoreboard (sum mod 2^64, count), and results arrive in order.
